// File: rtl/bscan_pkg.sv
// Shared types for the input-pad boundary-scan chain.
// TAP state encoding, instruction codes and next-state function.
package bscan_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SH_DR,
    ST_EX1_DR,
    ST_PAUSE_DR,
    ST_EX2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SH_IR,
    ST_EX1_IR,
    ST_PAUSE_IR,
    ST_EX2_IR,
    ST_UPD_IR
  } tap_state_t;

  typedef logic [1:0] ir_t;

  localparam ir_t IR_EXTEST  = 2'b00;
  localparam ir_t IR_SAMPLE  = 2'b01;
  localparam ir_t IR_INTEST  = 2'b10;
  localparam ir_t IR_BYPASS  = 2'b11;
  localparam ir_t IR_CAPTURE = 2'b01;

  function automatic tap_state_t tap_next(
    input tap_state_t s,
    input logic       tms
  );
    tap_state_t n;
    n = ST_TLR;
    unique case (s)
      ST_TLR:      n = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   n = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   n = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    n = tms ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   n = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: n = tms ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   n = tms ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   n = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   n = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    n = tms ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   n = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: n = tms ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   n = tms ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   n = tms ? ST_SEL_DR   : ST_RTI;
      default:     n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bscan_input_chain_if.sv
// Serial test port plus pad/core buses of the input chain.
// master drives tms/tdi/pad_in, slave is the scan chain.
interface bscan_input_chain_if #(
  parameter int N_PINS = 8
);

  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              tdo_en;
  logic [N_PINS-1:0] pad_in;
  logic [N_PINS-1:0] core_in;

  modport master (
    output tms,
    output tdi,
    output pad_in,
    input  tdo,
    input  tdo_en,
    input  core_in
  );

  modport slave (
    input  tms,
    input  tdi,
    input  pad_in,
    output tdo,
    output tdo_en,
    output core_in
  );

endinterface

// File: rtl/bscan_tap_fsm.sv
// 16-state TAP controller with registered one-hot action strobes.
// Strobes are loaded from the next state so they align with state.
module bscan_tap_fsm
  import bscan_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_t state,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir,
  output logic       tlr
);

  tap_state_t nxt;

  assign nxt = tap_next(state, tms);

  // advance the TAP and register the decoded strobes
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state  <= ST_TLR;
      cap_dr <= 1'b0;
      sh_dr  <= 1'b0;
      upd_dr <= 1'b0;
      cap_ir <= 1'b0;
      sh_ir  <= 1'b0;
      upd_ir <= 1'b0;
      tlr    <= 1'b1;
    end else begin
      state  <= nxt;
      cap_dr <= (nxt == ST_CAP_DR);
      sh_dr  <= (nxt == ST_SH_DR);
      upd_dr <= (nxt == ST_UPD_DR);
      cap_ir <= (nxt == ST_CAP_IR);
      sh_ir  <= (nxt == ST_SH_IR);
      upd_ir <= (nxt == ST_UPD_IR);
      tlr    <= (nxt == ST_TLR);
    end
  end

endmodule

// File: rtl/bscan_input_chain.sv
// Receive-side boundary-scan chain on the pad_in -> core_in path.
// Holds IR, bypass bit, BSR shift/update stages and output muxes.
module bscan_input_chain
  import bscan_pkg::*;
#(
  parameter int N_PINS = 8
) (
  input  logic                tck,
  input  logic                trst_n,
  bscan_input_chain_if.slave  jtag
);

  tap_state_t        state;
  logic              cap_dr;
  logic              sh_dr;
  logic              upd_dr;
  logic              cap_ir;
  logic              sh_ir;
  logic              upd_ir;
  logic              tlr;

  ir_t               ir;
  ir_t               ir_shift;
  logic              bypass;
  logic              sel_byp;
  logic [N_PINS-1:0] bsr_shift;
  logic [N_PINS-1:0] bsr_upd;
  logic [N_PINS-1:0] bsr_next;
  logic              tdo_c;

  bscan_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (jtag.tms),
    .state  (state),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir),
    .tlr    (tlr)
  );

  assign sel_byp = (ir == IR_BYPASS);

  // a single cell has no upper bits to move down
  generate
    if (N_PINS == 1) begin : g_one
      assign bsr_next = jtag.tdi;
    end else begin : g_many
      assign bsr_next = {jtag.tdi, bsr_shift[N_PINS-1:1]};
    end
  endgenerate

  // instruction register: capture, shift, update, TLR default
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir       <= IR_BYPASS;
      ir_shift <= '0;
    end else begin
      unique case (1'b1)
        tlr:     ir       <= IR_BYPASS;
        cap_ir:  ir_shift <= IR_CAPTURE;
        sh_ir:   ir_shift <= {jtag.tdi, ir_shift[1]};
        upd_ir:  ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  // data registers: bypass bit or boundary cells by instruction
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass    <= 1'b0;
      bsr_shift <= '0;
      bsr_upd   <= '0;
    end else begin
      unique case (1'b1)
        cap_dr: begin
          if (sel_byp) bypass    <= 1'b0;
          else         bsr_shift <= jtag.pad_in;
        end
        sh_dr: begin
          if (sel_byp) bypass    <= jtag.tdi;
          else         bsr_shift <= bsr_next;
        end
        upd_dr: begin
          if (!sel_byp) bsr_upd <= bsr_shift;
        end
        default: ;
      endcase
    end
  end

  // tdo comes from the LSB of whichever register is shifting
  always_comb begin
    tdo_c = 1'b0;
    unique case (1'b1)
      sh_ir:              tdo_c = ir_shift[0];
      sh_dr && sel_byp:   tdo_c = bypass;
      sh_dr && !sel_byp:  tdo_c = bsr_shift[0];
      default:            tdo_c = 1'b0;
    endcase
  end

  assign jtag.tdo     = tdo_c;
  assign jtag.tdo_en  = (state == ST_SH_DR) ||
                        (state == ST_SH_IR);
  assign jtag.core_in = (ir == IR_INTEST) ? bsr_upd
                                          : jtag.pad_in;

endmodule
